conv_tile_scheduler: RTL and testbench

- Sequences one convolution layer on the SYSTOLIC_SIZE x SYSTOLIC_SIZE array: filter-group loop outer, output-tile loop inner.
- Per tile, issues req/ack commands in order: weight load (first tile of each group only), IFM load, compute, OFM store.
- Sits between the top-level start/done interface and the load, PE and store datapath controllers; replaces the loop counters inside main control.

---
 rtl/conv_tile_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_conv_tile_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_tile_scheduler.sv
// Convolution layer tile scheduler: filter-group loop outer, output-tile loop inner,
// issuing weight/IFM/compute/store req-ack commands. Optional macro: TILE_SCHED_PERF_EN.
module conv_tile_scheduler #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int TS_W          = $clog2(SYSTOLIC_SIZE) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [8:0]      ifm_size,
  input  logic [10:0]     ifm_channel,
  input  logic [1:0]      kernel_size,
  input  logic [10:0]     num_filter,
  output logic            busy,
  output logic            done,
  output logic            cfg_err,
  output logic            wgt_req,
  input  logic            wgt_ack,
  output logic            ifm_req,
  input  logic            ifm_ack,
  output logic            cmp_req,
  input  logic            cmp_ack,
  output logic            ofm_req,
  input  logic            ofm_ack,
  output logic [7:0]      count_filter,
  output logic [11:0]     count_tiling,
  output logic [5:0]      tile_row,
  output logic [5:0]      tile_col,
  output logic [TS_W-1:0] tile_h,
  output logic [TS_W-1:0] tile_w,
`ifdef TILE_SCHED_PERF_EN
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_stall,
`endif
  output logic [TS_W-1:0] grp_filters
);

  localparam int S = SYSTOLIC_SIZE;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_ERR, S_WGT, S_IFM, S_CMP, S_STO, S_NXT, S_FIN
  } state_t;

  state_t state, state_n;

  logic [8:0]  ifm_size_r;
  logic [10:0] ifm_channel_r;
  logic [1:0]  kernel_r;
  logic [10:0] num_filter_r;
  logic [9:0]  ofm_r;
  logic [5:0]  tpd_r;
  logic [11:0] num_tiling_r;
  logic [7:0]  nlf_r;

  logic [9:0]  ofm_c;
  logic [5:0]  tpd_c;
  logic        cfg_bad;
  logic        start_ok;
  logic        last_tile;
  logic        last_grp;

  // Valid extent of a tile or filter group: whatever remains past idx full blocks, capped at S.
  function automatic logic [TS_W-1:0] edge_len(input int total, input int idx);
    int rem;
    rem = total - idx * S;
    return (rem >= S) ? TS_W'(S) : TS_W'(rem);
  endfunction

  assign ofm_c     = 10'(ifm_size_r) - 10'(kernel_r) + 10'd1;
  assign tpd_c     = 6'((int'(ofm_c) + S - 1) / S);
  assign cfg_bad   = (kernel_r == 2'd0) || (ifm_size_r < 9'(kernel_r)) ||
                     (ifm_channel_r == 11'd0) || (num_filter_r == 11'd0);
  assign start_ok  = (state == S_IDLE) && start;
  assign last_tile = (count_tiling == num_tiling_r - 12'd1);
  assign last_grp  = (count_filter == nlf_r - 8'd1);

  assign busy    = (state == S_CFG) || (state == S_WGT) || (state == S_IFM) ||
                   (state == S_CMP) || (state == S_STO) || (state == S_NXT);
  assign done    = (state == S_FIN) || (state == S_ERR);
  assign wgt_req = (state == S_WGT);
  assign ifm_req = (state == S_IFM);
  assign cmp_req = (state == S_CMP);
  assign ofm_req = (state == S_STO);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    // NOTE: next state defaults to the current state first, so no path can infer a latch.
    state_n = state;
    case (state)
      S_IDLE: if (start) state_n = S_CFG;
      S_CFG:  state_n = cfg_bad ? S_ERR : S_WGT;
      S_ERR:  state_n = S_IDLE;
      S_WGT:  if (wgt_ack) state_n = S_IFM;
      S_IFM:  if (ifm_ack) state_n = S_CMP;
      S_CMP:  if (cmp_ack) state_n = S_STO;
      S_STO:  if (ofm_ack) state_n = S_NXT;
      S_NXT:  begin
        if (!last_tile)     state_n = S_IFM;
        else if (!last_grp) state_n = S_WGT;
        else                state_n = S_FIN;
      end
      S_FIN:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: config shadows are reset with the counters so nothing derived from them leaks out after reset.
    if (rst) begin
      ifm_size_r    <= '0;
      ifm_channel_r <= '0;
      kernel_r      <= '0;
      num_filter_r  <= '0;
      ofm_r         <= '0;
      tpd_r         <= '0;
      num_tiling_r  <= '0;
      nlf_r         <= '0;
      cfg_err       <= 1'b0;
      count_filter  <= '0;
      count_tiling  <= '0;
      tile_row      <= '0;
      tile_col      <= '0;
      tile_h        <= '0;
      tile_w        <= '0;
      grp_filters   <= '0;
    end else if (start_ok) begin
      ifm_size_r    <= ifm_size;
      ifm_channel_r <= ifm_channel;
      kernel_r      <= kernel_size;
      num_filter_r  <= num_filter;
      cfg_err       <= 1'b0;
      count_filter  <= '0;
      count_tiling  <= '0;
      tile_row      <= '0;
      tile_col      <= '0;
    end else if (state == S_CFG) begin
      if (cfg_bad) begin
        cfg_err <= 1'b1;
      end else begin
        ofm_r        <= ofm_c;
        tpd_r        <= tpd_c;
        num_tiling_r <= 12'(int'(tpd_c) * int'(tpd_c));
        nlf_r        <= 8'((int'(num_filter_r) + S - 1) / S);
        tile_h       <= edge_len(int'(ofm_c), 0);
        tile_w       <= edge_len(int'(ofm_c), 0);
        grp_filters  <= edge_len(int'(num_filter_r), 0);
      end
    end else if (state == S_NXT) begin
      if (!last_tile) begin
        count_tiling <= count_tiling + 12'd1;
        if (tile_col == tpd_r - 6'd1) begin
          tile_col <= '0;
          tile_row <= tile_row + 6'd1;
          tile_w   <= edge_len(int'(ofm_r), 0);
          tile_h   <= edge_len(int'(ofm_r), int'(tile_row) + 1);
        end else begin
          tile_col <= tile_col + 6'd1;
          tile_w   <= edge_len(int'(ofm_r), int'(tile_col) + 1);
        end
      end else begin
        count_tiling <= '0;
        tile_row     <= '0;
        tile_col     <= '0;
        tile_h       <= edge_len(int'(ofm_r), 0);
        tile_w       <= edge_len(int'(ofm_r), 0);
        if (!last_grp) begin
          count_filter <= count_filter + 8'd1;
          grp_filters  <= edge_len(int'(num_filter_r), int'(count_filter) + 1);
        end
      end
    end
  end

`ifdef TILE_SCHED_PERF_EN
  logic stall_c;
  assign stall_c = (wgt_req && !wgt_ack) || (ifm_req && !ifm_ack) ||
                   (cmp_req && !cmp_ack) || (ofm_req && !ofm_ack);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (start_ok) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy)    perf_cycles <= perf_cycles + 32'd1;
      if (stall_c) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler: ack responder, phase monitor and hand-computed
// expectations for tiling, grouping, config errors, reset abort and ignored inputs.
module tb_conv_tile_scheduler;

  localparam int TS_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [8:0]      ifm_size;
  logic [10:0]     ifm_channel;
  logic [1:0]      kernel_size;
  logic [10:0]     num_filter;
  logic            busy, done, cfg_err;
  logic            wgt_req, ifm_req, cmp_req, ofm_req;
  logic [3:0]      ack_v;
  logic [7:0]      count_filter;
  logic [11:0]     count_tiling;
  logic [5:0]      tile_row, tile_col;
  logic [TS_W-1:0] tile_h, tile_w, grp_filters;
`ifdef TILE_SCHED_PERF_EN
  logic [31:0]     perf_cycles, perf_stall;
`endif

  conv_tile_scheduler dut (
    .clk(clk), .rst(rst), .start(start),
    .ifm_size(ifm_size), .ifm_channel(ifm_channel),
    .kernel_size(kernel_size), .num_filter(num_filter),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .wgt_req(wgt_req), .wgt_ack(ack_v[0]),
    .ifm_req(ifm_req), .ifm_ack(ack_v[1]),
    .cmp_req(cmp_req), .cmp_ack(ack_v[2]),
    .ofm_req(ofm_req), .ofm_ack(ack_v[3]),
    .count_filter(count_filter), .count_tiling(count_tiling),
    .tile_row(tile_row), .tile_col(tile_col),
    .tile_h(tile_h), .tile_w(tile_w),
`ifdef TILE_SCHED_PERF_EN
    .perf_cycles(perf_cycles), .perf_stall(perf_stall),
`endif
    .grp_filters(grp_filters)
  );

  always #5 clk = ~clk;

  wire [3:0] req_v = {ofm_req, cmp_req, ifm_req, wgt_req};

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct {int row; int col; int h; int w;} tile_t;

  // Monitor state: phase order (0=wgt 1=ifm 2=cmp 3=ofm) and snapshots at each req rise.
  bit      mon_en = 0;
  int      ph_q[$];
  int      wct_q[$];
  int      wcf_q[$];
  int      grp_q[$];
  tile_t   tile_q[$];
  int      done_n, err_done, viol;
  logic [3:0] prev_req = '0;

  always @(negedge clk) begin
    tile_t t;
    if (mon_en) begin
      if ($countones(req_v) > 1) viol++;
      for (int i = 0; i < 4; i++) begin
        if (req_v[i] && !prev_req[i]) begin
          ph_q.push_back(i);
          if (i == 0) begin
            wct_q.push_back(int'(count_tiling));
            wcf_q.push_back(int'(count_filter));
            grp_q.push_back(int'(grp_filters));
          end
          if (i == 1) begin
            t.row = int'(tile_row); t.col = int'(tile_col);
            t.h = int'(tile_h); t.w = int'(tile_w);
            tile_q.push_back(t);
          end
        end
        // ack here is the value sampled at the edge just passed
        if (prev_req[i] && !req_v[i] && !ack_v[i]) viol++;
        if (prev_req[i] && req_v[i] && ack_v[i]) viol++;
      end
      if (done) begin
        done_n++;
        if (cfg_err) err_done++;
      end
    end
    prev_req = req_v;
  end

  // Ack responder: 0 = driven by the main sequence, 1 = tied high, 2 = random 0..5 cycle delay.
  int ack_mode = 0;
  int dly[4];

  always begin
    @(negedge clk);
    #1;
    if (ack_mode == 1) begin
      ack_v = '1;
    end else if (ack_mode == 2) begin
      for (int i = 0; i < 4; i++) begin
        if (req_v[i] && !ack_v[i]) begin
          if (dly[i] == 0) ack_v[i] = 1'b1;
          else dly[i]--;
        end else if (!req_v[i] && ack_v[i]) begin
          ack_v[i] = 1'b0;
          dly[i] = $urandom_range(0, 5);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ph_q.delete(); wct_q.delete(); wcf_q.delete(); grp_q.delete(); tile_q.delete();
    done_n = 0; err_done = 0; viol = 0;
  endtask

  task automatic launch(input int ifm, input int k, input int ch, input int nf);
    tick();
    ifm_size = 9'(ifm); kernel_size = 2'(k); ifm_channel = 11'(ch); num_filter = 11'(nf);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    while (!done && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  function automatic int count_ph(input int p);
    int n = 0;
    foreach (ph_q[i]) if (ph_q[i] == p) n++;
    return n;
  endfunction

  task automatic check_order(input string tag, input int ngrp, input int ntile);
    int exp_q[$];
    int bad = 0;
    for (int g = 0; g < ngrp; g++) begin
      exp_q.push_back(0);
      for (int t = 0; t < ntile; t++) begin
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
      end
    end
    check({tag, "_phase_count"}, ph_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i >= ph_q.size() || ph_q[i] != exp_q[i]) bad++;
    check({tag, "_phase_order"}, bad, 0);
  endtask

  function automatic logic [63:0] all_out();
    return 64'({busy, done, cfg_err, wgt_req, ifm_req, cmp_req, ofm_req, count_filter,
                count_tiling, tile_row, tile_col, tile_h, tile_w, grp_filters});
  endfunction

  initial begin
    int lat;
    int n;
    rst = 1'b1; start = 1'b0; ack_v = '0;
    ifm_size = '0; ifm_channel = '0; kernel_size = '0; num_filter = '0;
    repeat (3) tick();
    check("reset_outputs_held", all_out(), 0);
    rst = 1'b0;
    tick();
    check("reset_outputs_idle", all_out(), 0);

    // 28/3/24/16 with acks tied high: ofm 26, 2x2 tiles, one filter group.
    clear_logs(); mon_en = 1; ack_mode = 1;
    launch(28, 3, 24, 16);
    check("c1_busy_after_start", busy, 1);
    wait_done(200, lat);
    check("c1_done_latency", lat, 18);
    check("c1_cfg_err", cfg_err, 0);
    check("c1_busy_at_done", busy, 0);
`ifdef TILE_SCHED_PERF_EN
    check("c1_perf_stall", perf_stall, 0);
    check("c1_perf_cycles", perf_cycles, 18);
`endif
    tick();
    check("c1_done_single", done_n, 1);
    check("c1_idle_after", {busy, done}, 0);
    check("c1_wgt_count", count_ph(0), 1);
    check("c1_ifm_count", count_ph(1), 4);
    check("c1_grp_filters", grp_q[0], 16);
    check("c1_t1_pos", {tile_q[1].row, tile_q[1].col}, {32'd0, 32'd1});
    check("c1_t1_size", {tile_q[1].h, tile_q[1].w}, {32'd16, 32'd10});
    check("c1_t2_size", {tile_q[2].h, tile_q[2].w}, {32'd10, 32'd16});
    check("c1_t3_size", {tile_q[3].h, tile_q[3].w}, {32'd10, 32'd10});
    check_order("c1", 1, 4);
    check("c1_protocol", viol, 0);

    // nf=40: three filter groups of 16, 16, 8.
    clear_logs();
    launch(28, 3, 24, 40);
    wait_done(400, lat);
    tick();
    check("c2_wgt_count", count_ph(0), 3);
    check("c2_ifm_count", count_ph(1), 12);
    for (int g = 0; g < 3; g++) check($sformatf("c2_wgt_tiling%0d", g), wct_q[g], 0);
    check("c2_grp_seq", {grp_q[0], grp_q[1], grp_q[2]}, {32'd16, 32'd16, 32'd8} );
    check("c2_filter_seq", {wcf_q[0], wcf_q[1], wcf_q[2]}, {32'd0, 32'd1, 32'd2});
    check_order("c2", 3, 4);
    check("c2_done_single", done_n, 1);

    // Random ack delays: ifm 20, k 1 -> ofm 20, 2x2 tiles of 16/4; nf 17 -> groups 16, 1.
    clear_logs();
    for (int i = 0; i < 4; i++) dly[i] = $urandom_range(0, 5);
    ack_mode = 2;
    launch(20, 1, 3, 17);
    wait_done(1500, lat);
    tick();
    check_order("c3", 2, 4);
    check("c3_protocol", viol, 0);
    check("c3_grp_seq", {grp_q[0], grp_q[1]}, {32'd16, 32'd1});
    check("c3_t3_size", {tile_q[3].h, tile_q[3].w}, {32'd4, 32'd4});
    check("c3_done_single", done_n, 1);

    // Illegal configs: kernel 3 on ifm 2, then nf 0.
    clear_logs(); ack_mode = 1;
    launch(2, 3, 1, 1);
    wait_done(20, lat);
    check("c4a_latency", lat, 1);
    check("c4a_err_with_done", {done, cfg_err}, 2'b11);
    tick();
    check("c4a_idle_after", {busy, done}, 0);
    check("c4a_no_req", ph_q.size(), 0);
    check("c4a_single_err", {done_n, err_done}, {32'd1, 32'd1});
    clear_logs();
    launch(28, 3, 24, 0);
    wait_done(20, lat);
    check("c4b_err_with_done", {done, cfg_err, busy}, 3'b110);
    tick();
    check("c4b_no_req", ph_q.size(), 0);
    check("c4b_single_err", {done_n, err_done}, {32'd1, 32'd1});

    // Reset while cmp_req is high, then a fresh full layer.
    launch(28, 3, 24, 16);
    check("c5_cfg_err_cleared", cfg_err, 0);
    n = 0;
    while (!cmp_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("c5_cmp_req_seen", cmp_req, 1);
    mon_en = 0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("c5_reset_abort", all_out(), 0);
    #1 rst = 1'b0;
    clear_logs(); mon_en = 1;
    launch(28, 3, 24, 16);
    wait_done(200, lat);
    tick();
    check("c5_first_group", wcf_q[0], 0);
    check_order("c5", 1, 4);
    check("c5_done_single", done_n, 1);

    // Start while busy plus a stray ifm_ack with no request: both ignored.
    clear_logs(); ack_mode = 0; ack_v = '0;
    launch(28, 3, 24, 16);
    n = 0;
    while (!wgt_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    #1;
    start = 1'b1; ack_v[1] = 1'b1;
    tick();
    start = 1'b0; ack_v[1] = 1'b0;
    tick();
    check("c6_still_wgt", {busy, wgt_req, ifm_req}, 3'b110);
    check("c6_counts", {count_filter, count_tiling}, 0);
    ack_mode = 1;
    wait_done(200, lat);
    tick();
    check_order("c6", 1, 4);
    check("c6_done_single", done_n, 1);

    // Start arriving in the FIN cycle is dropped.
    launch(28, 3, 24, 16);
    wait_done(200, lat);
    #1 start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("c6_fin_start_ignored", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
